// File: rtl/hpf_channel_scheduler_pkg.sv
// Shared constants for the multi-lead high-pass filter scheduler.
package hpf_channel_scheduler_pkg;

  localparam int DATA_W = 20;
  localparam int MAX_CH = 8;
  localparam int CH_W   = $clog2(MAX_CH);

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_REQ   = 2'd1;
  localparam state_t ST_CALC  = 2'd2;
  localparam state_t ST_WRITE = 2'd3;

endpackage

// File: rtl/hpf_channel_scheduler_hpf_step.sv
// One first-order high-pass update: y = y_prev - (y_prev >>> k) + x - x_prev.
// Wraps modulo 2^W; the shift floors toward minus infinity.
module hpf_step #(
  parameter int W = 20
) (
  input  logic signed [W-1:0] i_x,
  input  logic signed [W-1:0] i_x_prev,
  input  logic signed [W-1:0] i_y_prev,
  input  logic        [3:0]   i_k,
  output logic signed [W-1:0] o_y
);

  logic signed [W-1:0] w_shift;

  // Leaky feedback term plus input difference.
  always_comb begin
    w_shift = i_y_prev >>> i_k;
    o_y     = i_y_prev - w_shift + i_x - i_x_prev;
  end

endmodule

// File: rtl/hpf_channel_scheduler.sv
// Frame scheduler: on each divided tick fetches one ADC sample per lead,
// runs the shared hpf_step and emits a channel-tagged result.
module hpf_channel_scheduler
  import hpf_channel_scheduler_pkg::*;
#(
  parameter int N_CH        = 3,
  parameter int W           = DATA_W,
  parameter int SAMPLE_DIV  = 100000,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic            qzt_clk,
  input  logic            rst,
  input  logic            en,
  input  logic [3:0]      k,
  output logic            adc_req,
  output logic [CH_W-1:0] adc_ch,
  input  logic            adc_ack,
  input  logic [W-1:0]    adc_data,
  output logic [W-1:0]    vout,
  output logic [CH_W-1:0] vout_ch,
  output logic            vout_valid,
  output logic            busy,
  output logic            overrun,
  output logic            timeout_err,
  input  logic            clr_flags
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);

  logic [DIV_W-1:0]    r_div;
  logic                r_tick;
  state_t              r_state;
  logic [CH_W-1:0]     r_ch;
  logic [TO_W-1:0]     r_wait;
  logic [3:0]          r_k;
  logic signed [W-1:0] r_x;
  logic signed [W-1:0] r_y;
  logic signed [W-1:0] r_xp [N_CH];
  logic signed [W-1:0] r_yp [N_CH];
  logic                r_adc_req;
  logic [CH_W-1:0]     r_adc_ch;
  logic [W-1:0]        r_vout;
  logic [CH_W-1:0]     r_vout_ch;
  logic                r_vout_valid;
  logic                r_busy;
  logic                r_overrun;
  logic                r_timeout_err;

  logic [IDX_W-1:0]    w_idx;
  logic signed [W-1:0] w_y;
  logic                w_timeout;
  logic                w_overrun;

  assign w_idx     = r_ch[IDX_W-1:0];
  assign w_timeout = (r_state == ST_REQ) && !adc_ack && (r_wait == TO_LAST);
  assign w_overrun = r_tick && r_busy;

  hpf_step #(.W(W)) u_step (
    .i_x      (r_x),
    .i_x_prev (r_xp[w_idx]),
    .i_y_prev (r_yp[w_idx]),
    .i_k      (r_k),
    .o_y      (w_y)
  );

  // Free-running frame divider; the tick is registered and marks the wrap to 0.
  always_ff @(posedge qzt_clk) begin
    if (rst) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_div == DIV_LAST);
      if (r_div == DIV_LAST) r_div <= '0;
      else                   r_div <= r_div + 1'b1;
    end
  end

  // Frame FSM: request, filter, write back, one lead at a time.
  always_ff @(posedge qzt_clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ch         <= '0;
      r_wait       <= '0;
      r_k          <= 4'd0;
      r_x          <= '0;
      r_y          <= '0;
      r_adc_req    <= 1'b0;
      r_adc_ch     <= '0;
      r_vout       <= '0;
      r_vout_ch    <= '0;
      r_vout_valid <= 1'b0;
      r_busy       <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        r_xp[i] <= '0;
        r_yp[i] <= '0;
      end
    end else begin
      r_vout_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_tick && en) begin
            r_k       <= k;
            r_ch      <= '0;
            r_wait    <= '0;
            r_busy    <= 1'b1;
            r_adc_req <= 1'b1;
            r_adc_ch  <= '0;
            r_state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (adc_ack) begin
            r_x       <= adc_data;
            r_adc_req <= 1'b0;
            r_state   <= ST_CALC;
          end else if (r_wait == TO_LAST) begin
            // Abandon the lead: reuse the old input so the filter sees no step.
            r_x       <= r_xp[w_idx];
            r_adc_req <= 1'b0;
            r_state   <= ST_CALC;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        ST_CALC: begin
          // Result is published here so vout_valid coincides with WRITE.
          r_y          <= w_y;
          r_vout       <= w_y;
          r_vout_ch    <= r_ch;
          r_vout_valid <= 1'b1;
          r_state      <= ST_WRITE;
        end
        ST_WRITE: begin
          r_xp[w_idx] <= r_x;
          r_yp[w_idx] <= r_y;
          if (r_ch == CH_LAST) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_ch      <= r_ch + 1'b1;
            r_wait    <= '0;
            r_adc_req <= 1'b1;
            r_adc_ch  <= r_ch + 1'b1;
            r_state   <= ST_REQ;
          end
        end
        default: begin
          r_adc_req <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky error flags; a new event beats a simultaneous clear.
  always_ff @(posedge qzt_clk) begin
    if (rst) begin
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_overrun)      r_overrun <= 1'b1;
      else if (clr_flags) r_overrun <= 1'b0;
      if (w_timeout)      r_timeout_err <= 1'b1;
      else if (clr_flags) r_timeout_err <= 1'b0;
    end
  end

  assign adc_req     = r_adc_req;
  assign adc_ch      = r_adc_ch;
  assign vout        = r_vout;
  assign vout_ch     = r_vout_ch;
  assign vout_valid  = r_vout_valid;
  assign busy        = r_busy;
  assign overrun     = r_overrun;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_hpf_channel_scheduler.sv
// Directed bench for hpf_channel_scheduler with a behavioural ADC and a
// result monitor; expected filter outputs are hand-computed.
module tb_hpf_channel_scheduler;

  localparam int N_CH        = 3;
  localparam int W           = 20;
  localparam int SAMPLE_DIV  = 16;
  localparam int ACK_TIMEOUT = 6;

  logic         qzt_clk = 1'b0;
  logic         rst;
  logic         en;
  logic [3:0]   k;
  logic         adc_req;
  logic [2:0]   adc_ch;
  logic         adc_ack;
  logic [W-1:0] adc_data;
  logic [W-1:0] vout;
  logic [2:0]   vout_ch;
  logic         vout_valid;
  logic         busy;
  logic         overrun;
  logic         timeout_err;
  logic         clr_flags;

  int n_checks = 0;
  int n_fail   = 0;

  int ch_data [N_CH];
  int ack_delay = 0;
  int noack_ch  = 7;
  int ev_ch  [$];
  int ev_val [$];

  hpf_channel_scheduler #(
    .N_CH(N_CH), .W(W), .SAMPLE_DIV(SAMPLE_DIV), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .qzt_clk(qzt_clk), .rst(rst), .en(en), .k(k),
    .adc_req(adc_req), .adc_ch(adc_ch), .adc_ack(adc_ack), .adc_data(adc_data),
    .vout(vout), .vout_ch(vout_ch), .vout_valid(vout_valid),
    .busy(busy), .overrun(overrun), .timeout_err(timeout_err),
    .clr_flags(clr_flags)
  );

  always #5 qzt_clk = ~qzt_clk;

  // ADC model: acks after ack_delay request cycles, never for noack_ch.
  initial begin
    int cnt;
    cnt = 0;
    adc_ack  = 1'b0;
    adc_data = '0;
    forever begin
      @(negedge qzt_clk);
      if (adc_req === 1'b1 && int'(adc_ch) != noack_ch && int'(adc_ch) < N_CH) begin
        if (cnt >= ack_delay) begin
          adc_ack  = 1'b1;
          adc_data = W'(ch_data[adc_ch]);
          cnt      = 0;
        end else begin
          adc_ack = 1'b0;
          cnt++;
        end
      end else begin
        adc_ack = 1'b0;
        cnt     = 0;
      end
    end
  end

  // Result monitor: records every vout_valid pulse.
  initial begin
    forever begin
      @(negedge qzt_clk);
      if (vout_valid === 1'b1) begin
        ev_ch.push_back(int'(vout_ch));
        ev_val.push_back(int'($signed(vout)));
      end
    end
  end

  task automatic wait_events(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (ev_ch.size() >= n) break;
      @(negedge qzt_clk);
    end
    if (ev_ch.size() >= n) ok = 1'b1;
  endtask

  task automatic do_reset();
    en        = 1'b0;
    clr_flags = 1'b0;
    ack_delay = 0;
    noack_ch  = 7;
    rst       = 1'b1;
    repeat (2) @(negedge qzt_clk);
    rst = 1'b0;
    ev_ch.delete();
    ev_val.delete();
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    @(negedge qzt_clk);
    n_checks++;
    if (adc_req !== 1'b0 || adc_ch !== 3'd0) begin
      n_fail++; $display("FAIL reset_adc: req=%b ch=%0d, required 0/0", adc_req, adc_ch);
    end
    n_checks++;
    if (vout !== 20'd0 || vout_ch !== 3'd0 || vout_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_vout: vout=%0d ch=%0d v=%b, required 0", vout, vout_ch, vout_valid);
    end
    n_checks++;
    if (busy !== 1'b0 || overrun !== 1'b0 || timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: busy=%b ovr=%b to=%b, required 0", busy, overrun, timeout_err);
    end
    rst = 1'b0;
    // Several ticks pass with en low: no frame may start.
    repeat (40) @(negedge qzt_clk);
    n_checks++;
    if (busy !== 1'b0 || ev_ch.size() != 0) begin
      n_fail++; $display("FAIL en_low_ignored: busy=%b events=%0d, required 0/0", busy, ev_ch.size());
    end
  endtask

  task automatic test_step_response();
    bit ok;
    int exp_v [4];
    exp_v = '{0, 1000, 750, 563};
    do_reset();
    k = 4'd2;
    ch_data = '{0, 0, 0};
    en = 1'b1;
    wait_events(1, 60, ok);
    ch_data[0] = 1000;
    wait_events(12, 120, ok);
    en = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL step_events: got %0d events, required 12", ev_ch.size());
    end else begin
      for (int f = 0; f < 4; f++) begin
        n_checks++;
        if (ev_val[3*f] !== exp_v[f] || ev_ch[3*f] !== 0) begin
          n_fail++;
          $display("FAIL step_f%0d: vout=%0d ch=%0d, required %0d ch 0", f, ev_val[3*f], ev_ch[3*f], exp_v[f]);
        end
      end
    end
  endtask

  task automatic test_negative_floor();
    bit ok;
    int exp_v [3];
    exp_v = '{-1000, -750, -562};
    do_reset();
    k = 4'd2;
    ch_data = '{-1000, 0, 0};
    en = 1'b1;
    wait_events(9, 120, ok);
    en = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL neg_events: got %0d events, required 9", ev_ch.size());
    end else begin
      for (int f = 0; f < 3; f++) begin
        n_checks++;
        if (ev_val[3*f] !== exp_v[f]) begin
          n_fail++; $display("FAIL neg_f%0d: vout=%0d, required %0d", f, ev_val[3*f], exp_v[f]);
        end
      end
    end
  endtask

  task automatic test_multi_channel();
    bit ok;
    int exp_v [6];
    exp_v = '{100, 200, 300, 75, 150, 225};
    do_reset();
    k = 4'd2;
    ch_data = '{100, 200, 300};
    en = 1'b1;
    wait_events(6, 100, ok);
    en = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL multi_events: got %0d events, required 6", ev_ch.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (ev_val[i] !== exp_v[i] || ev_ch[i] !== i % 3) begin
          n_fail++;
          $display("FAIL multi_%0d: vout=%0d ch=%0d, required %0d ch %0d", i, ev_val[i], ev_ch[i], exp_v[i], i % 3);
        end
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int exp_v [3];
    exp_v = '{75, 150, 225};
    do_reset();
    k = 4'd2;
    ch_data = '{100, 200, 300};
    en = 1'b1;
    wait_events(3, 60, ok);
    n_checks++;
    if (timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_early: timeout_err=%b, required 0", timeout_err);
    end
    noack_ch = 1;
    wait_events(6, 80, ok);
    en = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL timeout_events: got %0d events, required 6", ev_ch.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (ev_val[3+i] !== exp_v[i] || ev_ch[3+i] !== i) begin
          n_fail++;
          $display("FAIL timeout_ch%0d: vout=%0d ch=%0d, required %0d ch %0d", i, ev_val[3+i], ev_ch[3+i], exp_v[i], i);
        end
      end
    end
    n_checks++;
    if (timeout_err !== 1'b1 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL timeout_flag: to=%b ovr=%b, required 1/0", timeout_err, overrun);
    end
    noack_ch  = 7;
    clr_flags = 1'b1;
    @(negedge qzt_clk);
    clr_flags = 1'b0;
    n_checks++;
    if (timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_clear: timeout_err=%b, required 0", timeout_err);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    int guard;
    do_reset();
    k = 4'd0;
    ack_delay = 4;
    ch_data = '{10, 20, 30};
    en = 1'b1;
    wait_events(6, 160, ok);
    en = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL ovr_events: got %0d events, required 6", ev_ch.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (ev_ch[i] !== i % 3 || ev_val[i] !== ((i < 3) ? 10 * (i + 1) : 0)) begin
          n_fail++;
          $display("FAIL ovr_order_%0d: ch=%0d vout=%0d, required ch %0d vout %0d",
                   i, ev_ch[i], ev_val[i], i % 3, (i < 3) ? 10 * (i + 1) : 0);
        end
      end
    end
    n_checks++;
    if (overrun !== 1'b1 || timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL ovr_flag: ovr=%b to=%b, required 1/0", overrun, timeout_err);
    end
    guard = 0;
    while (busy === 1'b1 && guard < 100) begin
      @(negedge qzt_clk);
      guard++;
    end
    clr_flags = 1'b1;
    @(negedge qzt_clk);
    clr_flags = 1'b0;
    n_checks++;
    if (overrun !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ovr_clear: ovr=%b busy=%b, required 0/0", overrun, busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    bit found;
    do_reset();
    k = 4'd2;
    ch_data = '{100, 100, 100};
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge qzt_clk);
      if (adc_req === 1'b1 && adc_ch === 3'd1) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found || ev_val.size() != 1 || ev_val[0] !== 100) begin
      n_fail++; $display("FAIL midrst_setup: found=%b events=%0d, required ch1 request after one ch0 result of 100", found, ev_val.size());
    end
    // The ack is driven now; the next cycle is CALC of ch1.
    @(negedge qzt_clk);
    rst = 1'b1;
    @(negedge qzt_clk);
    rst = 1'b0;
    n_checks++;
    if (vout !== 20'd0 || vout_ch !== 3'd0 || vout_valid !== 1'b0 || adc_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs: vout=%0d ch=%0d v=%b req=%b busy=%b, required all 0",
               vout, vout_ch, vout_valid, adc_req, busy);
    end
    ev_ch.delete();
    ev_val.delete();
    repeat (3) @(negedge qzt_clk);
    n_checks++;
    if (ev_ch.size() != 0) begin
      n_fail++; $display("FAIL midrst_no_valid: events=%0d, required 0", ev_ch.size());
    end
    ch_data[0] = 500;
    wait_events(1, 60, ok);
    en = 1'b0;
    n_checks++;
    if (!ok || ev_val[0] !== 500 || ev_ch[0] !== 0) begin
      n_fail++; $display("FAIL midrst_fresh: events=%0d first=%0d, required 500 on ch 0", ev_ch.size(), ok ? ev_val[0] : -1);
    end
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    k         = 4'd0;
    clr_flags = 1'b0;
    ch_data   = '{0, 0, 0};
    test_reset();
    test_step_response();
    test_negative_floor();
    test_multi_channel();
    test_timeout();
    test_overrun();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
